// File: rtl/boot_loader.sv
// Framed byte-stream loader: writes LEN payload bytes to RAM from BASE, checks the
// frame checksum, reads the image back to compare sums, then releases the processor.
module boot_loader #(
  parameter int                   DATAWIDTH = 8,
  parameter logic [DATAWIDTH-1:0] BASE      = '0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] address,
  output logic [DATAWIDTH-1:0] data_out,
  output logic                 write,
  input  logic [DATAWIDTH-1:0] mem_word,
  output logic                 cpu_run,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           o_dbg_state
);

  // Stream handshake: a byte transfers on the rising clk edge where in_valid && in_ready.
  // in_ready is registered and never depends on in_valid in the same cycle.
  typedef enum logic [2:0] {
    S_LEN    = 3'd0,
    S_DATA   = 3'd1,
    S_CHK    = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t               r_state;
  logic [DATAWIDTH-1:0] r_len;
  logic [DATAWIDTH-1:0] r_idx;
  logic [DATAWIDTH-1:0] r_data_sum;
  logic [DATAWIDTH-1:0] r_frame_sum;
  logic [DATAWIDTH-1:0] r_rb_sum;
  logic [DATAWIDTH-1:0] r_address;
  logic [DATAWIDTH-1:0] r_data_out;
  logic                 r_write;
  logic                 r_in_ready;
  logic                 r_cpu_run;
  logic                 r_done;
  logic                 r_err;

  logic                 w_fire;
  logic                 w_last;
  logic [DATAWIDTH-1:0] w_chk_sum;
  logic [DATAWIDTH-1:0] w_rb_next;

  assign w_fire    = in_valid & r_in_ready;
  assign w_last    = (r_idx == r_len - DATAWIDTH'(1));
  assign w_chk_sum = r_frame_sum + in_data;
  assign w_rb_next = r_rb_sum + mem_word;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_LEN;
      r_len       <= '0;
      r_idx       <= '0;
      r_data_sum  <= '0;
      r_frame_sum <= '0;
      r_rb_sum    <= '0;
      r_address   <= '0;
      r_data_out  <= '0;
      r_write     <= 1'b0;
      r_in_ready  <= 1'b0;
      r_cpu_run   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        // A byte arriving in S_ERR is the LEN of a fresh frame.
        S_LEN, S_ERR: begin
          r_in_ready <= 1'b1;
          if (w_fire) begin
            r_len       <= in_data;
            r_idx       <= '0;
            r_data_sum  <= '0;
            r_frame_sum <= in_data;
            r_err       <= 1'b0;
            r_state     <= (in_data == '0) ? S_CHK : S_DATA;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            r_address   <= BASE + r_idx;
            r_data_out  <= in_data;
            r_write     <= 1'b1;
            r_data_sum  <= r_data_sum + in_data;
            r_frame_sum <= r_frame_sum + in_data;
            r_idx       <= r_idx + DATAWIDTH'(1);
            if (w_last) r_state <= S_CHK;
          end
        end
        S_CHK: begin
          if (w_fire) begin
            if (w_chk_sum != '0) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (r_len == '0) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_run  <= 1'b1;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= S_VERIFY;
              r_in_ready <= 1'b0;
              r_idx      <= '0;
              r_rb_sum   <= '0;
              r_address  <= BASE;
            end
          end
        end
        // mem_word is combinational from address, so one word is summed per cycle.
        S_VERIFY: begin
          r_rb_sum <= w_rb_next;
          if (w_last) begin
            if (w_rb_next == r_data_sum) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_cpu_run <= 1'b1;
            end else begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_idx     <= r_idx + DATAWIDTH'(1);
            r_address <= BASE + r_idx + DATAWIDTH'(1);
          end
        end
        S_DONE: begin
          r_in_ready <= 1'b0;
        end
        default: begin
          r_state <= S_LEN;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign address     = r_address;
  assign data_out    = r_data_out;
  assign write       = r_write;
  assign cpu_run     = r_cpu_run;
  assign done        = r_done;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (BASE=0x00 and BASE=0xFE) share one byte stream,
// each with its own RAM; outcomes and write traffic are compared against a frame model.
module tb_boot_loader;

  localparam logic [7:0] BASE_A = 8'h00;
  localparam logic [7:0] BASE_B = 8'hFE;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       fault_on;

  logic       a_in_ready, a_write, a_cpu_run, a_done, a_err;
  logic [7:0] a_address, a_data_out, a_mem_word;
  logic [2:0] a_dbg;
  logic       b_in_ready, b_write, b_cpu_run, b_done, b_err;
  logic [7:0] b_address, b_data_out, b_mem_word;
  logic [2:0] b_dbg;

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];

  always #5 clk = ~clk;

  boot_loader #(.DATAWIDTH(8), .BASE(BASE_A)) dut_a (
    .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .address(a_address), .data_out(a_data_out), .write(a_write), .mem_word(a_mem_word),
    .cpu_run(a_cpu_run), .done(a_done), .err(a_err), .o_dbg_state(a_dbg)
  );

  boot_loader #(.DATAWIDTH(8), .BASE(BASE_B)) dut_b (
    .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .address(b_address), .data_out(b_data_out), .write(b_write), .mem_word(b_mem_word),
    .cpu_run(b_cpu_run), .done(b_done), .err(b_err), .o_dbg_state(b_dbg)
  );

  // RAM models; fault_on makes address 0x01 read back as zero
  assign a_mem_word = (fault_on && a_address == 8'h01) ? 8'h00 : ram_a[a_address];
  assign b_mem_word = (fault_on && b_address == 8'h01) ? 8'h00 : ram_b[b_address];

  // ---------------- scoreboard ----------------
  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  logic [15:0] got_a[$];
  logic [15:0] got_b[$];
  logic [7:0]  cur_pay[$];
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) begin
    if (a_write) begin
      ram_a[a_address] = a_data_out;
      got_a.push_back({a_address, a_data_out});
    end
    if (b_write) begin
      ram_b[b_address] = b_data_out;
      got_b.push_back({b_address, b_data_out});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit chk_ok(input logic [7:0] chk);
    int s = cur_pay.size() + chk;
    foreach (cur_pay[i]) s += cur_pay[i];
    return (s % 256) == 0;
  endfunction

  // returns {done, err}
  function automatic logic [1:0] model(input logic [7:0] base, input bit fault, input logic [7:0] chk);
    int dsum = 0;
    int rsum = 0;
    if (!chk_ok(chk)) return 2'b01;
    if (cur_pay.size() == 0) return 2'b10;
    foreach (cur_pay[i]) begin
      dsum += cur_pay[i];
      if (!(fault && ((base + i) % 256) == 1)) rsum += cur_pay[i];
    end
    return ((dsum % 256) == (rsum % 256)) ? 2'b10 : 2'b01;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    clr = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic run_frame(input logic [7:0] chk, input int gap, input bit rst, input bit fault,
                           input bit use_tab, input logic [1:0] tab_exp);
    logic [1:0] ea, eb;
    int k = 0;
    int lat;
    if (rst) reset_dut();
    fault_on = fault;
    got_a.delete(); got_b.delete(); exp_a_q.delete(); exp_b_q.delete();
    foreach (cur_pay[i]) begin
      exp_a_q.push_back({8'(BASE_A + 8'(i)), cur_pay[i]});
      exp_b_q.push_back({8'(BASE_B + 8'(i)), cur_pay[i]});
    end
    send_byte(8'(cur_pay.size()), gap);
    foreach (cur_pay[i]) send_byte(cur_pay[i], gap);
    send_byte(chk, gap);
    while (!(a_done || a_err) && k < 300) begin @(posedge clk); #1; k++; end
    ea  = use_tab ? tab_exp : model(BASE_A, fault, chk);
    eb  = model(BASE_B, fault, chk);
    lat = (!chk_ok(chk) || cur_pay.size() == 0) ? 0 : cur_pay.size();
    check("a_latency", k, lat);
    check("a_done", a_done, ea[1]);
    check("a_err", a_err, ea[0]);
    check("a_cpu_run", a_cpu_run, ea[1]);
    check("b_done", b_done, eb[1]);
    check("b_err", b_err, eb[0]);
    check("b_cpu_run", b_cpu_run, eb[1]);
    check("a_wr_count", got_a.size(), exp_a_q.size());
    check("b_wr_count", got_b.size(), exp_b_q.size());
    for (int i = 0; i < got_a.size() && i < exp_a_q.size(); i++) check("a_wr", got_a[i], exp_a_q[i]);
    for (int i = 0; i < got_b.size() && i < exp_b_q.size(); i++) check("b_wr", got_b[i], exp_b_q[i]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  len;
    logic [31:0] d;       // payload byte i at d[8*i +: 8]
    logic [7:0]  chk;
    int          gap;
    bit          rst;
    bit          fault;
    logic [1:0]  exp_a;   // {done, err} for the BASE=0 instance
  } vec_t;

  vec_t tab[6];

  task automatic load_pay(input int t);
    cur_pay.delete();
    for (int i = 0; i < tab[t].len; i++) cur_pay.push_back(tab[t].d[8*i +: 8]);
  endtask

  initial begin
    tab[0] = '{len: 8'd3, d: 32'h00332211, chk: 8'h97, gap: 0, rst: 1, fault: 0, exp_a: 2'b10};
    tab[1] = '{len: 8'd3, d: 32'h00332211, chk: 8'h00, gap: 0, rst: 1, fault: 0, exp_a: 2'b01};
    tab[2] = '{len: 8'd3, d: 32'h00332211, chk: 8'h97, gap: 0, rst: 0, fault: 0, exp_a: 2'b10};
    tab[3] = '{len: 8'd0, d: 32'h00000000, chk: 8'h00, gap: 0, rst: 1, fault: 0, exp_a: 2'b10};
    tab[4] = '{len: 8'd4, d: 32'hA3A2A1A0, chk: 8'h76, gap: 1, rst: 1, fault: 0, exp_a: 2'b10};
    tab[5] = '{len: 8'd3, d: 32'h00332211, chk: 8'h97, gap: 0, rst: 1, fault: 1, exp_a: 2'b01};

    for (int i = 0; i < 256; i++) begin ram_a[i] = 8'h00; ram_b[i] = 8'h00; end
    fault_on = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    clr      = 1'b1;
    #1 clr = 1'b0;
    #2;
    check("reset_outputs_a", {a_in_ready, a_write, a_cpu_run, a_done, a_err, a_address, a_data_out, a_dbg}, 32'd0);
    check("reset_outputs_b", {b_in_ready, b_write, b_cpu_run, b_done, b_err, b_address, b_data_out, b_dbg}, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    clr = 1'b1;
    #1;
    check("ready_before_edge", a_in_ready, 1'b0);
    @(posedge clk); #1;
    check("ready_after_edge", a_in_ready, 1'b1);

    // table-driven frames
    for (int t = 0; t < 6; t++) begin
      load_pay(t);
      run_frame(tab[t].chk, tab[t].gap, tab[t].rst, tab[t].fault, 1'b1, tab[t].exp_a);
    end

    // DONE ignores the stream
    load_pay(0);
    run_frame(8'h97, 0, 1'b1, 1'b0, 1'b0, 2'b00);
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("done_hold", {a_done, a_cpu_run, a_in_ready, a_err}, 4'b1100);
    check("done_no_writes", got_a.size(), 3);

    // reset mid-load after the 2nd of 3 payload bytes
    reset_dut();
    for (int i = 0; i < 256; i++) ram_a[i] = 8'h00;
    got_a.delete();
    send_byte(8'd3, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    check("midload_write_pending", a_write, 1'b1);
    clr = 1'b0;
    #1;
    check("midload_reset_outputs", {a_in_ready, a_write, a_cpu_run, a_done, a_err, a_address, a_data_out}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    check("midload_write_count", got_a.size(), 1);
    check("midload_ram0", ram_a[0], 8'h11);
    check("midload_ram1", ram_a[1], 8'h00);
    load_pay(0);
    run_frame(8'h97, 0, 1'b0, 1'b0, 1'b0, 2'b00);

    // randomized frames against the model
    for (int r = 0; r < 24; r++) begin
      int n = $urandom_range(0, 10);
      int s;
      logic [7:0] chk;
      cur_pay.delete();
      for (int i = 0; i < n; i++) cur_pay.push_back(8'($urandom));
      s = n;
      foreach (cur_pay[i]) s += cur_pay[i];
      chk = ($urandom_range(0, 3) != 0) ? 8'((256 - (s % 256)) % 256) : 8'($urandom);
      run_frame(chk, $urandom_range(0, 2), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream program loader that owns the RAM write port before the processor runs. It accepts a framed image over a valid/ready stream and writes it into sequential RAM addresses. It then reads the image back to verify it, and releases the processor only after a clean load. It is the writer/initiator counterpart to the memory unit and sits between an external byte source and the RAM port, ahead of the processor.

## Interface
- DATAWIDTH, 8, width of data bytes and of RAM addresses
- BASE, 0, first RAM address written (DATAWIDTH bits)

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-low reset
- in_data  in  DATAWIDTH  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept; transfer on rising clk when in_valid && in_ready
- address  out  DATAWIDTH  RAM address
- data_out  out  DATAWIDTH  RAM write data
- write  out  1  RAM write strobe; RAM writes on the rising clk edge where write=1
- mem_word  in  DATAWIDTH  RAM read data, combinational from address
- cpu_run  out  1  1 = processor released; the top level holds the processor in clear while 0
- done  out  1  image loaded and verified
- err  out  1  last frame failed

## Operation
- Frame format: LEN (N, 0..255), then N payload bytes, then CHK.
- Checksum rule: LEN + all payload bytes + CHK ≡ 0 mod 2^DATAWIDTH.
- Payload byte i is written to address (BASE+i) mod 2^DATAWIDTH. Addresses wrap with no error.
- States:
  - S_LEN: accept LEN, clear sums and index. N=0 → S_CHK; else → S_DATA.
  - S_DATA: on each handshake:
    - register address and byte, pulse write for exactly one cycle;
    - add the byte to data_sum and frame_sum; increment i.
    - After byte N → S_CHK.
  - S_CHK: accept CHK.
    - Sum ≠ 0 → S_ERR.
    - Sum = 0 and N=0 → S_DONE.
    - Otherwise → S_VERIFY.
  - S_VERIFY: one read per cycle.
    - Drive address=(BASE+j) for j=0..N-1 and accumulate mem_word into rb_sum.
    - After j=N-1: rb_sum == data_sum → S_DONE; else → S_ERR.
  - S_DONE: terminal. in_ready=0, cpu_run=1, done=1. Stream is ignored until reset.
  - S_ERR: err=1, cpu_run=0, in_ready=1. A handshake here is taken as a new LEN: err clears and the frame restarts exactly as in S_LEN.
- in_ready = 1 in S_LEN, S_DATA, S_CHK and S_ERR; 0 in S_VERIFY and S_DONE. Backpressure is applied only during verify and after done.
- All sums use DATAWIDTH bits and wrap modulo 2^DATAWIDTH.
- write is never asserted outside the cycle following a payload handshake.

## Timing
- Reset:
  - While clr=0 all outputs are 0: in_ready, write, cpu_run, done, err, address, data_out.
  - The state is S_LEN.
  - in_ready goes to 1 in the first cycle after clr rises.
- Write latency: a payload accepted at edge E drives write=1 with valid address/data during the cycle after E. RAM captures it at edge E+1.
- Back-to-back payload bytes give one write per cycle. No byte is dropped and no stall is inserted.
- CHK may be accepted at the edge where the final write commits. Verify reads start the next cycle and always see committed data.
- Done latency: with N≥1, S_DONE/S_ERR is entered N edges after the CHK handshake edge. With N=0, S_DONE is entered at the CHK edge.
- cpu_run, done and err are registered outputs and change only on state entry.
- Reset mid-frame (clr low in any state):
  - the state machine aborts immediately to S_LEN and any pending write pulse is dropped;
  - RAM keeps whatever was already written;
  - cpu_run=0 until a full good frame completes.
- In S_DONE, in_valid has no effect on any output.

## Test plan
- Good frame, BASE=0: LEN=0x03, data 0x11 0x22 0x33, CHK=0x97 → writes 0x11@0x00, 0x22@0x01, 0x33@0x02. done=1, cpu_run=1 three edges after the CHK edge; err=0.
- Bad checksum then recovery: same frame with CHK=0x00 → err=1, cpu_run=0, no verify reads. Then send the good frame → err clears, done=1.
- Empty frame: LEN=0x00, CHK=0x00 → no write pulses; done=1 at the CHK edge.
- Wrap and backpressure: BASE=0xFE, LEN=4, data 0xA0..0xA3 with in_valid toggling every other cycle → writes at 0xFE, 0xFF, 0x00, 0x01. Exactly 4 write pulses; done=1.
- Verify failure: RAM model forces address 0x01 to read back 0x00 → S_ERR, err=1, cpu_run stays 0.
- Reset mid-load: pull clr low after the 2nd of 3 payload bytes → all outputs 0 at once, write never re-pulses. After release, the good frame loads and done=1.
